// File: rtl/raster_stream_tx.sv
// Raster-order frame reader: memory reads to a valid/ready pixel stream with sof/eol/eof.
// Optional ROW_STRIDE_EN adds a row_stride port for non-contiguous line starts.
module raster_stream_tx #(
  parameter int DATA_W     = 8,
  parameter int DIM_W      = 16,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef ROW_STRIDE_EN
  input  logic [DIM_W-1:0]  row_stride,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int EW = DATA_W + 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef ROW_STRIDE_EN
  logic [DIM_W-1:0]  stride_q, stride_d;
`endif
  logic              inflt_q, inflt_d;
  logic [2:0]        iflg_q, iflg_d;
  logic [EW-1:0]     fifo_q [2];
  logic [EW-1:0]     fifo_d [2];
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              pop;
  logic              at_eol;
  logic              at_last;
  logic [2:0]        flg;
  logic [EW-1:0]     head;

  always_comb begin
    head    = fifo_q[rp_q];
    pop     = (cnt_q != 2'd0) && m_ready;
    at_eol  = col_q == w_q - DIM_W'(1);
    at_last = at_eol && (row_q == h_q - DIM_W'(1));
    flg     = {(row_q == '0) && (col_q == '0), at_eol, at_last};
    // A beat leaving this cycle frees a slot for a read issued now.
    mem_rd_en = (state_q == RUN) &&
                ((({1'b0, cnt_q} + {2'b0, inflt_q}) < 3'(FIFO_DEPTH)) || pop);
`ifdef ROW_STRIDE_EN
    mem_addr = addr_q + ADDR_W'(col_q);
`else
    mem_addr = addr_q;
`endif

    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
`ifdef ROW_STRIDE_EN
    stride_d = stride_q;
`endif
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d    = width;
          h_d    = height;
          addr_d = base_addr;
          col_d  = '0;
          row_d  = '0;
`ifdef ROW_STRIDE_EN
          stride_d = row_stride;
`endif
          if ((width == '0) || (height == '0)) done_d = 1'b1;
          else state_d = RUN;
        end
      end
      RUN: begin
        if (mem_rd_en) begin
          if (at_eol) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
`ifdef ROW_STRIDE_EN
            addr_d = addr_q + ADDR_W'(stride_q);
`endif
          end else begin
            col_d = col_q + DIM_W'(1);
          end
`ifndef ROW_STRIDE_EN
          addr_d = addr_q + ADDR_W'(1);
`endif
          if (at_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head[DATA_W]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    inflt_d = mem_rd_en;
    iflg_d  = mem_rd_en ? flg : iflg_q;

    fifo_d = fifo_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (inflt_q) begin
      fifo_d[wp_q] = {iflg_q, mem_rd_data};
      wp_d         = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + {1'b0, inflt_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
`ifdef ROW_STRIDE_EN
      stride_q  <= '0;
`endif
      inflt_q   <= 1'b0;
      iflg_q    <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
`ifdef ROW_STRIDE_EN
      stride_q  <= stride_d;
`endif
      inflt_q   <= inflt_d;
      iflg_q    <= iflg_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign m_valid = cnt_q != 2'd0;
  assign {m_sof, m_eol, m_eof, m_data} = head;

endmodule

// File: tb/tb_raster_stream_tx.sv
// Bench for raster_stream_tx: frame model from raster rules, randomized
// backpressure and frame sizes, plus literal expectations for fixed frames.
module tb_raster_stream_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] width = '0;
  logic [15:0] height = '0;
  logic [15:0] base_addr = '0;
  logic [15:0] row_stride = '0;
  logic        busy, done, mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_sof, m_eol, m_eof;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mode = 0;
  int ph = 0;

  logic [15:0] exp_addr[$];
  logic [10:0] exp_beat[$];
  logic [15:0] rd_log[$];
  logic [10:0] beat_log[$];
  logic        mbusy = 1'b0;
  logic        pend_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_beat = '0;
  int issued = 0, popped = 0;
  int start_cyc = 0, first_rd = -1, first_v = -1, done_cyc = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  raster_stream_tx dut (
    .clk(clk), .rst(rst), .start(start),
    .width(width), .height(height), .base_addr(base_addr),
`ifdef ROW_STRIDE_EN
    .row_stride(row_stride),
`endif
    .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  function automatic logic [7:0] pix(input logic [15:0] a);
    return a[15:8] ^ (a[7:0] * 8'd13 + 8'd7);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Synchronous memory: data the cycle after the read strobe.
  initial forever begin
    @(posedge clk);
    if (mem_rd_en) mem_rd_data <= pix(mem_addr);
  end

  initial forever begin
    @(posedge clk);
    #1;
    ph++;
    case (mode)
      0: m_ready = 1'b1;
      1: m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model and per-cycle compare.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      exp_addr.delete();
      exp_beat.delete();
      mbusy = 1'b0;
      pend_done = 1'b0;
      prev_stall = 1'b0;
      issued = 0;
      popped = 0;
    end else begin
      logic [10:0] act;
      act = {m_sof, m_eol, m_eof, m_data};
      chk("done", done, pend_done);
      chk("busy", busy, mbusy);
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      chk("outstanding_le_2", 32'(issued - popped <= 2), 1);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_hold", act, prev_beat);
      end
      pend_done = 1'b0;
      if (start && !mbusy) begin
        int w, h, s;
        start_cyc = cyc;
        first_rd = -1;
        first_v = -1;
        rd_log.delete();
        beat_log.delete();
        w = int'(width);
        h = int'(height);
`ifdef ROW_STRIDE_EN
        s = int'(row_stride);
`else
        s = w;
`endif
        if (w == 0 || h == 0) pend_done = 1'b1;
        else begin
          mbusy = 1'b1;
          for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
              logic [15:0] a;
              a = 16'(int'(base_addr) + r * s + c);
              exp_addr.push_back(a);
              exp_beat.push_back({(r == 0 && c == 0), (c == w - 1),
                                  (c == w - 1 && r == h - 1), pix(a)});
            end
        end
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (mem_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        rd_log.push_back(mem_addr);
        issued++;
        if (exp_addr.size() == 0) fail("extra_read", 1, 0);
        else chk("rd_addr", mem_addr, exp_addr.pop_front());
      end
      if (m_valid && m_ready) begin
        popped++;
        beat_log.push_back(act);
        if (exp_beat.size() == 0) fail("extra_beat", 1, 0);
        else begin
          logic [10:0] e;
          e = exp_beat.pop_front();
          chk("beat", act, e);
          if (e[8]) begin
            pend_done = 1'b1;
            mbusy = 1'b0;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_beat = act;
    end
  end

  task automatic do_start(input int w, input int h, input int b, input int s);
    @(posedge clk);
    #1;
    width = 16'(w);
    height = 16'(h);
    base_addr = 16'(b);
    row_stride = 16'(s);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic frame(input int w, input int h, input int b, input int s);
    int d0, n;
    d0 = done_seen;
    n = 0;
    do_start(w, h, b, s);
    while (done_seen == d0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (done_seen == d0) fail("frame_timeout", n, 400);
    repeat (2) @(posedge clk);
    chk("drained", exp_beat.size(), 0);
  endtask

  initial begin
    logic [2:0] f1 [6];
    int n;
    f1 = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b000, 3'b011};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    mode = 0;
    frame(3, 2, 16'h10, 0);
    chk("t1_reads", rd_log.size(), 6);
    chk("t1_beats", beat_log.size(), 6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++)
      chk("t1_addr", rd_log[i], 16'h10 + i);
    for (int i = 0; i < 6 && i < beat_log.size(); i++)
      chk("t1_flags", beat_log[i][10:8], f1[i]);
    chk("t1_first_rd_lat", first_rd - start_cyc, 1);
    chk("t1_first_valid_lat", first_v - start_cyc, 3);
    chk("t1_done_lat", done_cyc - start_cyc, 9);

    mode = 1;
    frame(3, 2, 16'h10, 0);
    chk("t2_beats", beat_log.size(), 6);
    for (int i = 0; i < 6 && i < beat_log.size(); i++) begin
      chk("t2_flags", beat_log[i][10:8], f1[i]);
      chk("t2_data", beat_log[i][7:0], pix(16'(16'h10 + i)));
    end

    mode = 0;
    frame(0, 4, 16'h20, 0);
    chk("t3_no_reads", rd_log.size(), 0);
    chk("t3_no_valid", 32'(first_v), 32'(-1));
    chk("t3_done_lat", done_cyc - start_cyc, 1);

    frame(1, 1, 16'h123, 1);
    chk("t4_beats", beat_log.size(), 1);
    if (beat_log.size() > 0) chk("t4_flags", beat_log[0][10:8], 3'b111);

    do_start(4, 4, 16'h40, 4);
    repeat (3) @(posedge clk);
    #1;
    width = 16'd2;
    height = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (beat_log.size() < 8 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (beat_log.size() < 8) fail("t5_beat7_timeout", beat_log.size(), 8);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_beats_before_rst", beat_log.size(), 8);
    n = done_seen;
    repeat (4) @(posedge clk);
    chk("t5_no_done", done_seen, n);
    frame(4, 4, 16'h40, 4);
    chk("t5_full_frame", beat_log.size(), 16);

`ifdef ROW_STRIDE_EN
    frame(2, 3, 0, 8);
    chk("t6_reads", rd_log.size(), 6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++)
      chk("t6_addr", rd_log[i], (i / 2) * 8 + (i % 2));
    for (int i = 0; i < 6 && i < beat_log.size(); i++)
      chk("t6_eol", beat_log[i][9], i % 2);
`endif

    mode = 2;
    frame(3, 2, 16'hFFFE, 3);
    chk("t7_wrap_reads", rd_log.size(), 6);
    if (rd_log.size() > 2) chk("t7_wrap_addr", rd_log[2], 16'h0000);

    for (int i = 0; i < 8; i++) begin
      mode = $urandom_range(0, 2);
      frame($urandom_range(1, 5), $urandom_range(1, 4),
            int'($urandom_range(0, 65535)), $urandom_range(0, 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
